// File: rtl/hdb3_err_mon.sv
// HDB3 line-rule monitor: flags illegal codes, long zero runs, misplaced and
// same-polarity bipolar violations, tracks loss of signal and a windowed error count.
module hdb3_err_mon #(
  parameter int unsigned LOS_LEN = 16,
  parameter int unsigned WIN     = 1000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_hdb3_code,
  output logic             o_err,
  output logic [3:0]       o_err_type,
  output logic             o_los,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_cnt_valid
);

  localparam int unsigned ZW = $clog2(LOS_LEN + 1);
  localparam int unsigned SW = $clog2(WIN);

  localparam logic [0:0] ST_LOS   = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // cause bit positions inside o_err_type
  localparam int unsigned B_ILL  = 3;
  localparam int unsigned B_ZERO = 2;
  localparam int unsigned B_BPV  = 1;
  localparam int unsigned B_VPOL = 0;

  logic [0:0]       r_state;
  logic             r_last_neg;
  logic [ZW-1:0]    r_zrun;
  logic             r_lastv_neg;
  logic             r_lastv_vld;
  logic [SW-1:0]    r_sym_cnt;
  logic [CNT_W-1:0] r_acc;
  logic             r_err;
  logic [3:0]       r_err_type;
  logic             r_los;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_cnt_valid;

  logic [0:0]       w_state_nxt;
  logic             w_last_neg_nxt;
  logic             w_lastv_neg_nxt;
  logic             w_lastv_vld_nxt;
  logic [3:0]       w_type;
  logic             w_pulse;
  logic             w_neg;
  logic             w_ill;
  logic [ZW-1:0]    w_zrun_nxt;
  logic             w_los_hit;
  logic             w_err;
  logic [CNT_W-1:0] w_acc_inc;
  logic             w_win_end;

  // symbol decode and zero-run update (00 and 11 both extend the run)
  always_comb begin
    w_pulse = (i_hdb3_code == 2'b01) || (i_hdb3_code == 2'b10);
    w_neg   = (i_hdb3_code == 2'b10);
    w_ill   = (i_hdb3_code == 2'b11);
    if (w_pulse) begin
      w_zrun_nxt = '0;
    end else if (r_zrun == ZW'(LOS_LEN)) begin
      w_zrun_nxt = r_zrun;
    end else begin
      w_zrun_nxt = r_zrun + ZW'(1);
    end
    w_los_hit = !w_pulse && (w_zrun_nxt == ZW'(LOS_LEN));
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_LOS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and line-rule checks
  always_comb begin
    w_state_nxt     = r_state;
    w_last_neg_nxt  = r_last_neg;
    w_lastv_neg_nxt = r_lastv_neg;
    w_lastv_vld_nxt = r_lastv_vld;
    w_type          = 4'b0000;
    case (r_state)
      ST_LOS: begin
        if (w_pulse) begin
          w_state_nxt     = ST_TRACK;
          w_last_neg_nxt  = w_neg;
          w_lastv_vld_nxt = 1'b0;
        end
      end
      ST_TRACK: begin
        if (w_los_hit) begin
          // the LOS-triggering zero carries no error of its own
          w_state_nxt = ST_LOS;
        end else if (w_pulse) begin
          w_last_neg_nxt = w_neg;
          if (w_neg == r_last_neg) begin
            w_lastv_neg_nxt = w_neg;
            w_lastv_vld_nxt = 1'b1;
            if ((r_zrun != ZW'(2)) && (r_zrun != ZW'(3))) begin
              w_type[B_BPV] = 1'b1;
            end else if (r_lastv_vld && (r_lastv_neg == w_neg)) begin
              w_type[B_VPOL] = 1'b1;
            end
          end
        end else begin
          w_type[B_ILL]  = w_ill;
          w_type[B_ZERO] = (w_zrun_nxt == ZW'(4));
        end
      end
      default: begin
        w_state_nxt = ST_LOS;
      end
    endcase
  end

  // error window accumulation
  always_comb begin
    w_err = |w_type;
    if (w_err && (r_acc != CNT_MAX)) begin
      w_acc_inc = r_acc + CNT_W'(1);
    end else begin
      w_acc_inc = r_acc;
    end
    w_win_end = (r_sym_cnt == SW'(WIN - 1));
  end

  // tracking state, window counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_neg  <= 1'b0;
      r_zrun      <= '0;
      r_lastv_neg <= 1'b0;
      r_lastv_vld <= 1'b0;
      r_sym_cnt   <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
      r_err_type  <= 4'b0000;
      r_los       <= 1'b1;
      r_err_cnt   <= '0;
      r_cnt_valid <= 1'b0;
    end else begin
      r_last_neg  <= w_last_neg_nxt;
      r_zrun      <= w_zrun_nxt;
      r_lastv_neg <= w_lastv_neg_nxt;
      r_lastv_vld <= w_lastv_vld_nxt;
      r_err       <= w_err;
      r_err_type  <= w_type;
      r_los       <= (w_state_nxt == ST_LOS);
      if (w_win_end) begin
        r_sym_cnt   <= '0;
        r_acc       <= '0;
        r_err_cnt   <= w_acc_inc;
        r_cnt_valid <= 1'b1;
      end else begin
        r_sym_cnt   <= r_sym_cnt + SW'(1);
        r_acc       <= w_acc_inc;
        r_cnt_valid <= 1'b0;
      end
    end
  end

  assign o_err       = r_err;
  assign o_err_type  = r_err_type;
  assign o_los       = r_los;
  assign o_err_cnt   = r_err_cnt;
  assign o_cnt_valid = r_cnt_valid;

endmodule

// File: tb/tb_hdb3_err_mon.sv
// Scoreboard bench for hdb3_err_mon: one instance for line rules, one small-window
// instance (WIN=8, CNT_W=2) for the saturating error count.
module tb_hdb3_err_mon;

  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] I = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [1:0]  code  = 2'b00;
  logic        a_err;
  logic [3:0]  a_type;
  logic        a_los;
  logic [15:0] a_cnt;
  logic        a_cnt_valid;

  logic        w_rst_n = 1'b0;
  logic [1:0]  w_code  = 2'b00;
  logic        w_err;
  logic [3:0]  w_type;
  logic        w_los;
  logic [1:0]  w_cnt;
  logic        w_cnt_valid;

  hdb3_err_mon #(.LOS_LEN(16), .WIN(1000), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hdb3_code(code),
    .o_err(a_err), .o_err_type(a_type), .o_los(a_los),
    .o_err_cnt(a_cnt), .o_cnt_valid(a_cnt_valid)
  );

  hdb3_err_mon #(.LOS_LEN(16), .WIN(8), .CNT_W(2)) u_win (
    .i_clk(clk), .i_rst_n(w_rst_n), .i_hdb3_code(w_code),
    .o_err(w_err), .o_err_type(w_type), .o_los(w_los),
    .o_err_cnt(w_cnt), .o_cnt_valid(w_cnt_valid)
  );

  typedef struct packed {
    logic [3:0] typ;
    logic       los;
    logic       rst;
  } exp_t;

  exp_t       q_line[$];
  logic [1:0] q_cnt[$];
  logic       q_zchk[$];
  int         n_vec = 0;
  int         n_mis = 0;
  int         n_sym = 0;
  logic       chk_end  = 1'b0;
  logic       end_done = 1'b0;

  // monitor: one pop per sampled symbol, plus window strobes and end-of-run drain checks
  always @(posedge clk) begin : mon
    exp_t       e;
    logic [1:0] c;
    #1;
    if (q_line.size() > 0) begin
      e = q_line.pop_front();
      n_sym++;
      n_vec++;
      if (a_err !== (|e.typ) || a_type !== e.typ || a_los !== e.los ||
          (e.rst && (a_cnt_valid !== 1'b0 || a_cnt !== 16'd0))) begin
        n_mis++;
        $display("FAIL line sym %0d: err=%b type=%b los=%b cv=%b cnt=%0d, want err=%b type=%b los=%b",
                 n_sym, a_err, a_type, a_los, a_cnt_valid, a_cnt, |e.typ, e.typ, e.los);
      end
    end
    if (q_zchk.size() > 0) begin
      void'(q_zchk.pop_front());
      n_vec++;
      if (w_cnt_valid !== 1'b0 || w_cnt !== 2'd0) begin
        n_mis++;
        $display("FAIL win reset: cnt_valid=%b cnt=%0d, want 0/0", w_cnt_valid, w_cnt);
      end
    end
    if (w_cnt_valid === 1'b1) begin
      n_vec++;
      if (q_cnt.size() == 0) begin
        n_mis++;
        $display("FAIL win strobe: unexpected strobe cnt=%0d", w_cnt);
      end else begin
        c = q_cnt.pop_front();
        if (w_cnt !== c) begin
          n_mis++;
          $display("FAIL win count: cnt=%0d, want %0d", w_cnt, c);
        end
      end
    end
    if (chk_end && !end_done) begin
      n_vec++;
      if (q_line.size() != 0) begin
        n_mis++;
        $display("FAIL line drain: %0d expected symbols left", q_line.size());
      end
      n_vec++;
      if (q_cnt.size() != 0) begin
        n_mis++;
        $display("FAIL win drain: %0d expected strobes never seen", q_cnt.size());
      end
      end_done = 1'b1;
    end
  end

  task automatic line_sym(input logic [1:0] c, input logic [3:0] t, input logic l);
    @(negedge clk);
    rst_n = 1'b1;
    code  = c;
    q_line.push_back({t, l, 1'b0});
  endtask

  task automatic line_rst();
    @(negedge clk);
    rst_n = 1'b0;
    code  = 2'($urandom);
    q_line.push_back({4'b0000, 1'b1, 1'b1});
  endtask

  task automatic win_sym(input logic [1:0] c, input int exp_cnt);
    @(negedge clk);
    w_rst_n = 1'b1;
    w_code  = c;
    if (exp_cnt >= 0) q_cnt.push_back(2'(exp_cnt));
  endtask

  task automatic win_rst(input logic chk);
    @(negedge clk);
    w_rst_n = 1'b0;
    w_code  = 2'($urandom);
    if (chk) q_zchk.push_back(1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0] b;
    // reset with random symbols, then release before any pulse
    repeat (3) line_rst();
    line_sym(Z, 4'b0000, 1'b1);
    line_sym(I, 4'b0000, 1'b1);
    line_sym(Z, 4'b0000, 1'b1);
    // legal stream: first +1 leaves LOS
    line_sym(P, 4'b0000, 1'b0);
    line_sym(N, 4'b0000, 1'b0);
    repeat (3) line_sym(Z, 4'b0000, 1'b0);
    line_sym(N, 4'b0000, 1'b0);
    line_sym(P, 4'b0000, 1'b0);
    repeat (2) line_sym(Z, 4'b0000, 1'b0);
    line_sym(P, 4'b0000, 1'b0);
    // 2000 zero data bits: B00V groups alternating polarity, first group negative
    for (int k = 0; k < 500; k++) begin
      b = (k % 2 == 0) ? N : P;
      line_sym(b, 4'b0000, 1'b0);
      line_sym(Z, 4'b0000, 1'b0);
      line_sym(Z, 4'b0000, 1'b0);
      line_sym(b, 4'b0000, 1'b0);
    end
    // BPV: V after a single zero
    line_sym(N, 4'b0000, 1'b0);
    line_sym(P, 4'b0000, 1'b0);
    line_sym(Z, 4'b0000, 1'b0);
    line_sym(P, 4'b0010, 1'b0);
    // VPOL: legal V- followed by a second V-
    line_sym(N, 4'b0000, 1'b0);
    line_sym(P, 4'b0000, 1'b0);
    line_sym(N, 4'b0000, 1'b0);
    repeat (3) line_sym(Z, 4'b0000, 1'b0);
    line_sym(N, 4'b0000, 1'b0);
    line_sym(P, 4'b0000, 1'b0);
    line_sym(N, 4'b0000, 1'b0);
    repeat (2) line_sym(Z, 4'b0000, 1'b0);
    line_sym(N, 4'b0001, 1'b0);
    // zero run to LOS and recovery
    for (int i = 1; i <= 20; i++)
      line_sym(Z, (i == 4) ? 4'b0100 : 4'b0000, (i >= 16) ? 1'b1 : 1'b0);
    line_sym(N, 4'b0000, 1'b0);
    line_sym(I, 4'b1000, 1'b0);
    line_sym(Z, 4'b0000, 1'b0);
    line_sym(Z, 4'b0000, 1'b0);
    line_sym(I, 4'b1100, 1'b0);
    line_sym(P, 4'b0000, 1'b0);

    // window instance: 3 errors, then 5 errors saturating at 3
    win_sym(P, -1);
    repeat (3) win_sym(I, -1);
    win_sym(N, -1);
    win_sym(P, -1);
    win_sym(N, -1);
    win_sym(P, 3);
    repeat (5) win_sym(I, -1);
    win_sym(N, -1);
    win_sym(P, -1);
    win_sym(N, 3);
    // reset at symbol 5 of a window: no strobe, count cleared, window restarts
    repeat (4) win_sym(Z, -1);
    win_rst(1'b1);
    win_rst(1'b1);
    repeat (7) win_sym(Z, -1);
    win_sym(Z, 0);

    repeat (3) @(negedge clk);
    chk_end = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(negedge clk);
    if (!end_done) begin
      n_vec++;
      n_mis++;
      $display("FAIL end: monitor drain check never ran");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
